sens_avg_filter: RTL

- Downstream stage of the sensor receiver. Consumes its 16-bit distance word and level-type write strobe.
- Applies a power-of-two moving-average window and flags a stale sensor via a clk_en-based watchdog.
- Emits a one-cycle memory write (data + address) of the filtered distance for the PID core.
- Replaces direct raw-sample writes to the sensor data memory slot.

---
 rtl/sens_avg_filter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sens_avg_filter.sv
// rtl/sens_avg_filter.sv - power-of-two moving-average filter with clk_en watchdog for the sensor slot.
// Optional outlier rejection is built when SENS_OUTLIER_REJECT_EN is defined.
module sens_avg_filter #(
  parameter int WIDTH         = 16,
  parameter int LOG2_DEPTH    = 2,
  parameter int TIMEOUT_TICKS = 19200,
  parameter int ADDR_WIDTH    = 5,
  parameter int MEM_ADDR      = 13,
  parameter int MAX_STEP      = 50
) (
  input  logic                  clk_in_i,
  input  logic                  reset_i,
  input  logic                  clk_en_i,
  input  logic [WIDTH-1:0]      sample_i,
  input  logic                  sample_valid_i,
  output logic [WIDTH-1:0]      filt_data_o,
  output logic                  filt_write_o,
  output logic [ADDR_WIDTH-1:0] filt_addr_o,
  output logic                  filt_ready_o,
  output logic                  sens_timeout_o,
  output logic                  rejected_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam int WD_W  = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic             WD_EN    = (TIMEOUT_TICKS > 0);
`ifdef SENS_OUTLIER_REJECT_EN
  localparam logic             OUTLIER_EN = 1'b1;
`else
  localparam logic             OUTLIER_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  sv_d1_q, sv_d2_q;
  logic [WIDTH-1:0]      sample_q, sample_d;
  logic [WIDTH-1:0]      win_q [DEPTH];
  logic [WIDTH-1:0]      win_d [DEPTH];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic                  rej_pass_q, rej_pass_d;
  logic [1:0]            rej_cnt_q, rej_cnt_d;

  logic                  accept_c;
  logic                  wd_hit_c;
  logic                  reject_c;
  logic [WIDTH-1:0]      diff_c;

  // The strobe is registered twice so the edge detector sees a clean, synchronised level.
  assign accept_c = sv_d1_q && !sv_d2_q && (state_q == ST_IDLE);
  assign wd_hit_c = WD_EN && (wd_q == WD_MAX);

  always_comb begin
    diff_c   = (sample_q >= data_q) ? (sample_q - data_q) : (data_q - sample_q);
    reject_c = OUTLIER_EN && ready_q && (diff_c > WIDTH'(MAX_STEP)) && (rej_cnt_q != 2'd3);
  end

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    win_d      = win_q;
    sum_d      = sum_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    data_d     = data_q;
    write_d    = 1'b0;
    ready_d    = ready_q;
    rej_pass_d = rej_pass_q;
    rej_cnt_d  = rej_cnt_q;

    if (WD_EN && clk_en_i && (wd_q != WD_MAX)) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (wd_hit_c) begin
      timeout_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sample_d  = sample_i;
          state_d   = ST_UPDATE;
          wd_d      = '0;
          timeout_d = 1'b0;
        end else if (wd_hit_c) begin
          // Stale sensor: restart the window from empty but keep the last published value.
          for (int i = 0; i < DEPTH; i++) begin
            win_d[i] = '0;
          end
          sum_d   = '0;
          ptr_d   = '0;
          count_d = '0;
          ready_d = 1'b0;
        end
      end
      ST_UPDATE: begin
        state_d = ST_OUTPUT;
        if (reject_c) begin
          rej_pass_d = 1'b1;
          rej_cnt_d  = rej_cnt_q + 2'd1;
        end else begin
          rej_pass_d   = 1'b0;
          rej_cnt_d    = 2'd0;
          sum_d        = sum_q + SUM_W'(sample_q) - SUM_W'(win_q[ptr_q]);
          win_d[ptr_q] = sample_q;
          ptr_d        = ptr_q + 1'b1;
          if (count_q != CNT_FULL) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        state_d = ST_IDLE;
        if ((count_q == CNT_FULL) && !rej_pass_q) begin
          data_d  = WIDTH'(sum_q >> LOG2_DEPTH);
          write_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sv_d1_q    <= 1'b0;
      sv_d2_q    <= 1'b0;
      sample_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q      <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      data_q     <= '0;
      write_q    <= 1'b0;
      ready_q    <= 1'b0;
      rej_pass_q <= 1'b0;
      rej_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      sv_d1_q    <= sample_valid_i;
      sv_d2_q    <= sv_d1_q;
      sample_q   <= sample_d;
      win_q      <= win_d;
      sum_q      <= sum_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      rej_pass_q <= rej_pass_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign filt_data_o    = data_q;
  assign filt_write_o   = write_q;
  assign filt_addr_o    = ADDR_WIDTH'(MEM_ADDR);
  assign filt_ready_o   = ready_q;
  assign sens_timeout_o = timeout_q;
  assign rejected_o     = (state_q == ST_UPDATE) && reject_c;

endmodule
